ram_arbiter: RTL

Two-requester arbiter and sequencer for the 64×8 single-port `Simple_Ram`, which has a shared `addr`/`data` bus, a `wnr` strobe and a registered `q`. It accepts read and write commands from two independent clients over a valid/ready handshake. It serialises the commands onto the RAM port and returns read data with a one-cycle response pulse. It sits between the RAM instance and its clients; the clients never drive the RAM directly.

---
 rtl/ram_arb_pkg.sv | 12 +
 rtl/ram_arb_pick.sv | 22 ++
 rtl/ram_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester Simple_Ram arbiter.
package ram_arb_pkg;
  localparam int NUM_REQ    = 2;
  localparam int RAM_ADDR_W = 6;
  localparam int RAM_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RDWAIT
  } state_e;
endpackage

// File: rtl/ram_arb_pick.sv
// Combinational two-way grant select; RAM_ARB_RR_EN selects round-robin on ties,
// otherwise req0 has fixed priority and the last-grant input is ignored.
module ram_arb_pick import ram_arb_pkg::*; (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               last_i,
  output logic               gnt_o,
  output logic               any_o
);
  assign any_o = |valid_i;

`ifdef RAM_ARB_RR_EN
  always_comb begin
    gnt_o = valid_i[1];
    // On a tie, favour whoever was not granted last time.
    if (valid_i[0] && valid_i[1]) gnt_o = ~last_i;
  end
`else
  logic unused_last;
  assign unused_last = last_i;
  assign gnt_o       = ~valid_i[0] & valid_i[1];
`endif
endmodule

// File: rtl/ram_arbiter.sv
// Serialises two clients' read/write commands onto a single-port RAM; reads respond 3 cycles
// after accept, writes take 2. Clients wait with ready=0 while busy. RAM_ARB_RR_EN enables round-robin.
module ram_arbiter import ram_arb_pkg::*; #(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_wnr,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_wnr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wnr,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);
  state_e              state_q;
  logic                id_q;
  logic                wnr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                rsp0_valid_q, rsp1_valid_q;
  logic [DATA_W-1:0]   rsp0_rdata_q, rsp1_rdata_q;
  logic                last_q;
  logic                gnt, any_req;
  logic                wnr_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   data_d;

  ram_arb_pick u_pick (
    .valid_i ({req1_valid, req0_valid}),
    .last_i  (last_q),
    .gnt_o   (gnt),
    .any_o   (any_req)
  );

`ifdef RAM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (state_q == ST_IDLE && any_req) begin
      last_q <= gnt;
    end
  end
`else
  assign last_q = 1'b1;
`endif

  always_comb begin
    wnr_d  = gnt ? req1_wnr   : req0_wnr;
    addr_d = gnt ? req1_addr  : req0_addr;
    data_d = gnt ? req1_wdata : req0_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      id_q         <= 1'b0;
      wnr_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            id_q    <= gnt;
            wnr_q   <= wnr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: state_q <= wnr_q ? ST_IDLE : ST_RDWAIT;
        ST_RDWAIT: begin
          // ram_q now reflects the address presented during ACCESS.
          if (id_q) begin
            rsp1_rdata_q <= ram_q;
            rsp1_valid_q <= 1'b1;
          end else begin
            rsp0_rdata_q <= ram_q;
            rsp0_valid_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req0_ready = (state_q == ST_IDLE) & any_req & ~gnt & ~rst;
  assign req1_ready = (state_q == ST_IDLE) & any_req &  gnt & ~rst;
  assign ram_addr   = addr_q;
  assign ram_data   = data_q;
  assign ram_wnr    = (state_q == ST_ACCESS) & wnr_q & ~rst;
  assign busy       = (state_q != ST_IDLE);
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;
endmodule
